// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle between the PC sequencer and its neighbours:
// hazard unit, branch/jump resolution and instruction memory.
interface pc_sequencer_if #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
);
  logic            imem_ready_i;
  logic            stall_i;
  logic            br_taken_i;
  logic [PC_W-1:0] br_target_i;
  logic            jump_i;
  logic [PC_W-1:0] jump_target_i;

  logic [PC_W-1:0]  pc_o;
  logic             pc_valid_o;
  logic             flush_if_id_o;
  logic             flush_id_ex_o;
  logic             refill_o;
  logic [CNT_W-1:0] br_count_o;
  logic [CNT_W-1:0] jmp_count_o;

  modport master (
    input  imem_ready_i,
    input  stall_i,
    input  br_taken_i,
    input  br_target_i,
    input  jump_i,
    input  jump_target_i,
    output pc_o,
    output pc_valid_o,
    output flush_if_id_o,
    output flush_id_ex_o,
    output refill_o,
    output br_count_o,
    output jmp_count_o
  );

  modport slave (
    output imem_ready_i,
    output stall_i,
    output br_taken_i,
    output br_target_i,
    output jump_i,
    output jump_target_i,
    input  pc_o,
    input  pc_valid_o,
    input  flush_if_id_o,
    input  flush_id_ex_o,
    input  refill_o,
    input  br_count_o,
    input  jmp_count_o
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner: next-PC select, pipeline flush strobes,
// post-branch refill window and saturating redirect statistics.
module pc_sequencer #(
  parameter int              PC_W          = 32,
  parameter logic [PC_W-1:0] RESET_PC      = '0,
  parameter int              REFILL_CYCLES = 2,
  parameter int              CNT_W         = 16
) (
  input logic            clk,
  input logic            rst_n,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    REFILL
  } state_t;

  localparam logic [2:0] REFILL_INIT = 3'(REFILL_CYCLES);

  state_t     state;
  logic [2:0] refill_cnt;
  logic       take_br;
  logic       take_jmp;
  logic       advance;

  assign take_br  = (state == RUN) && bus.br_taken_i;
  assign take_jmp = (state == RUN) && bus.jump_i
                    && !bus.stall_i;
  assign advance  = !bus.stall_i && bus.imem_ready_i;

  // Flushes are strobes for the next edge, so they stay combinational.
  assign bus.flush_if_id_o = take_br || take_jmp;
  assign bus.flush_id_ex_o = take_br;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= BOOT;
      refill_cnt      <= '0;
      bus.pc_o        <= RESET_PC;
      bus.pc_valid_o  <= 1'b0;
      bus.refill_o    <= 1'b0;
      bus.br_count_o  <= '0;
      bus.jmp_count_o <= '0;
    end else begin
      unique case (state)
        BOOT: begin
          state          <= RUN;
          bus.pc_valid_o <= 1'b1;
        end
        RUN: begin
          if (bus.br_taken_i) begin
            bus.pc_o     <= bus.br_target_i;
            refill_cnt   <= REFILL_INIT;
            state        <= REFILL;
            bus.refill_o <= 1'b1;
            if (bus.br_count_o != '1)
              bus.br_count_o <= bus.br_count_o + 1'b1;
          end else if (take_jmp) begin
            bus.pc_o <= bus.jump_target_i;
            if (bus.jmp_count_o != '1)
              bus.jmp_count_o <= bus.jmp_count_o + 1'b1;
          end else if (advance) begin
            bus.pc_o <= bus.pc_o + 1'b1;
          end
        end
        REFILL: begin
          // Wrong-path redirects are ignored; the window is time-based.
          if (advance)
            bus.pc_o <= bus.pc_o + 1'b1;
          refill_cnt <= refill_cnt - 1'b1;
          if (refill_cnt == 3'd1) begin
            state        <= RUN;
            bus.refill_o <= 1'b0;
          end
        end
        default: begin
          state        <= BOOT;
          bus.refill_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
